// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time controller for an external 32-bit ALU; runs unsigned multiply as shift-add steps and owns icc.
// Latency: single op rsp_valid 2 cycles after request handshake; multiply rsp_valid 33 cycles after handshake.
// Backpressure: req_ready only in IDLE; response held stable in DONE until rsp_ready, no request accepted meanwhile.
module alu_sequencer #(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic        req_mul,
  input  logic        req_setcc,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_y,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic [31:0] rsp_hi,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  icc,
  input  logic        icc_wr_en,
  input  logic [3:0]  icc_wr_data,
  output logic        busy
);

  localparam int CW = $clog2(MUL_STEPS);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     opcode_q;
  logic           setcc_q;
  logic [31:0]    a_q;        // operand A, doubles as the multiplicand
  logic [31:0]    b_q;
  logic [31:0]    acc_hi;     // running high product word
  logic [31:0]    mq;         // multiplier bits still to consume, low product bits shift in from the top
  logic [CW-1:0]  count;

  logic           req_fire;
  logic           exec_go;
  logic           mul_step;
  logic           mul_last;
  logic           carry;
  logic [31:0]    acc_hi_nxt;
  logic [31:0]    mq_nxt;
  logic [3:0]     flags_nxt;
  logic           icc_upd;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign req_fire  = req_valid && req_ready;
  assign exec_go   = (state == EXEC) && !kill;
  assign mul_step  = (state == MUL) && !kill;
  assign mul_last  = mul_step && (count == CW'(MUL_STEPS - 1));

  // Multiply step arithmetic: the ALU add's carry-out is recovered from the unsigned wrap,
  // then the 65-bit {carry, sum, mq} pair shifts right by one.
  always_comb begin
    carry      = (alu_y < acc_hi);
    acc_hi_nxt = {carry, alu_y[31:1]};
    mq_nxt     = {alu_y[0], mq[31:1]};
    flags_nxt  = 4'b0000;
    if (state == EXEC) begin
      // Opcodes 1010-1111 produce no architectural flags
      flags_nxt = (opcode_q < 4'd10) ? alu_flags : 4'b0000;
    end else if (state == MUL) begin
      flags_nxt = {(mq_nxt == '0), mq_nxt[31], 2'b00};
    end
    icc_upd = setcc_q && ((exec_go && (opcode_q < 4'd10)) || mul_last);
  end

  // Next-state and ALU port drive
  always_comb begin
    state_nxt  = state;
    alu_opcode = 4'b1101;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_mul ? MUL : EXEC;
      end
      EXEC: begin
        alu_opcode = opcode_q;
        alu_a      = a_q;
        alu_b      = b_q;
        alu_cin    = icc[1];
        state_nxt  = kill ? IDLE : DONE;
      end
      MUL: begin
        alu_opcode = 4'b0000;
        alu_a      = acc_hi;
        alu_b      = mq[0] ? a_q : '0;
        if (kill)          state_nxt = IDLE;
        else if (mul_last) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture, multiply accumulator and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= '0;
      setcc_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      mq        <= '0;
      count     <= '0;
      rsp_y     <= '0;
      rsp_hi    <= '0;
      rsp_flags <= '0;
    end else begin
      if (req_fire) begin
        opcode_q <= req_opcode;
        setcc_q  <= req_setcc;
        a_q      <= req_a;
        b_q      <= req_b;
        acc_hi   <= '0;
        mq       <= req_b;
        count    <= '0;
      end
      if (mul_step) begin
        acc_hi <= acc_hi_nxt;
        mq     <= mq_nxt;
        count  <= count + CW'(1);
      end
      if (exec_go) begin
        rsp_y     <= alu_y;
        rsp_hi    <= '0;
        rsp_flags <= flags_nxt;
      end
      if (mul_last) begin
        rsp_y     <= mq_nxt;
        rsp_hi    <= acc_hi_nxt;
        rsp_flags <= flags_nxt;
      end
    end
  end

  // Condition codes: a completing setcc op takes precedence over the direct write path
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          icc <= '0;
    else if (icc_upd)   icc <= flags_nxt;
    else if (icc_wr_en) icc <= icc_wr_data;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checks of alu_sequencer against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: exercises rsp_ready hold-off and kill aborts.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_mul, req_setcc, kill;
  logic [3:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_cin;
  logic [3:0]  alu_opcode, alu_flags;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y, rsp_hi;
  logic [3:0]  rsp_flags, icc, icc_wr_data;
  logic        icc_wr_en, busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  icc_m   = 4'b0000;
  logic [31:0] last_y  = '0;
  logic [31:0] last_hi = '0;

  alu_sequencer #(.MUL_STEPS(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_mul(req_mul), .req_setcc(req_setcc), .req_a(req_a), .req_b(req_b),
    .kill(kill),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_hi(rsp_hi),
    .rsp_flags(rsp_flags), .icc(icc), .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU: returns {Z,N,C,V, y}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        s = {1'b0, a} + {1'b0, b} + ((op == 4'd1) ? {32'd0, cin} : 33'd0);
        y = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'd2, 4'd3: begin
        s = {1'b0, a} - {1'b0, b} - ((op == 4'd3) ? {32'd0, cin} : 33'd0);
        y = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'd4:    y = a & b;
      4'd5:    y = a | b;
      4'd6:    y = a ^ b;
      4'd7:    y = a & ~b;
      4'd8:    y = a << b[4:0];
      4'd9:    y = a >> b[4:0];
      4'd10:   y = $unsigned($signed(a) >>> b[4:0]);
      4'd11:   y = b;
      4'd12:   y = ~a;
      4'd13:   y = a;
      4'd14:   y = ~b;
      default: y = '0;
    endcase
    return {(y == 32'd0), y[31], c, v, y};
  endfunction

  always_comb {alu_flags, alu_y} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_icc(input logic [3:0] d);
    icc_wr_en = 1'b1; icc_wr_data = d;
    @(negedge clk);
    icc_wr_en = 1'b0;
    icc_m = d;
    check("icc_direct_write", icc, d);
  endtask

  // One full transaction: issue, latency, result, optional hold-off, return to idle.
  task automatic run_op(input bit mul, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit setcc, input int hold, input bit kidle, input bit wr_exec);
    logic [63:0] prod;
    logic [35:0] r;
    logic [31:0] ey, ehi;
    logic [3:0]  ef, eicc;
    int          lat;
    if (mul) begin
      prod = {32'd0, a} * {32'd0, b};
      ey = prod[31:0]; ehi = prod[63:32]; ef = {(ey == 32'd0), ey[31], 2'b00};
    end else begin
      r = alu_fn(op, a, b, icc_m[1]);
      ey = r[31:0]; ehi = '0; ef = (op < 4'd10) ? r[35:32] : 4'b0000;
    end
    if (setcc && (mul || op < 4'd10)) eicc = ef;
    else if (wr_exec)                 eicc = 4'hF;
    else                              eicc = icc_m;

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_mul = mul; req_opcode = op; req_a = a; req_b = b; req_setcc = setcc;
    kill = kidle; rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    req_a = $urandom; req_b = $urandom; req_opcode = 4'($urandom); req_mul = 1'($urandom);
    lat = 1;
    check("busy_after_issue", busy, 1);
    if (mul) begin
      check("mul_alu_ctrl", {alu_opcode, alu_cin}, {4'd0, 1'b0});
    end else begin
      check("exec_alu_opcode", alu_opcode, op);
      check("exec_alu_cin", alu_cin, icc_m[1]);
    end
    if (wr_exec) begin icc_wr_en = 1'b1; icc_wr_data = 4'hF; end
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      icc_wr_en = 1'b0;
      lat++;
    end
    icc_wr_en = 1'b0;
    check("latency", lat, mul ? 33 : 2);
    check("rsp_y", rsp_y, ey);
    check("rsp_hi", rsp_hi, ehi);
    check("rsp_flags", rsp_flags, ef);
    check("icc", icc, eicc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_result", {rsp_hi, rsp_y}, {ehi, ey});
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_accept", {rsp_valid, busy, req_ready}, 3'b001);
    icc_m = eicc; last_y = ey; last_hi = ehi;
  endtask

  // Abort an operation after 'step' cycles in EXEC/MUL; optional direct icc write in the kill cycle.
  task automatic kill_op(input bit mul, input int step, input bit wr);
    bit seen;
    req_valid = 1'b1; req_mul = mul; req_opcode = 4'd0; req_a = $urandom; req_b = $urandom | 32'h1;
    req_setcc = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (step) @(negedge clk);
    kill = 1'b1;
    if (wr) begin icc_wr_en = 1'b1; icc_wr_data = 4'b0101; end
    @(negedge clk);
    kill = 1'b0; icc_wr_en = 1'b0;
    if (wr) icc_m = 4'b0101;
    check("kill_to_idle", {busy, req_ready, rsp_valid}, 3'b010);
    check("kill_icc", icc, icc_m);
    check("kill_rsp_kept", {rsp_hi, rsp_y}, {last_hi, last_y});
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= rsp_valid; end
    check("kill_no_rsp", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    reset = 1'b1; req_valid = 1'b0; req_mul = 1'b0; req_setcc = 1'b0; req_opcode = '0;
    req_a = '0; req_b = '0; kill = 1'b0; rsp_ready = 1'b0; icc_wr_en = 1'b0; icc_wr_data = '0;
    repeat (2) @(negedge clk);
    check("reset_ready_busy_valid", {req_ready, busy, rsp_valid}, 3'b100);
    check("reset_rsp", {rsp_hi, rsp_y}, 64'd0);
    check("reset_flags_icc", {rsp_flags, icc}, 8'd0);
    check("reset_alu_idle", {alu_opcode, alu_a, alu_b, alu_cin}, {4'b1101, 65'd0});
    reset = 1'b0;
    @(negedge clk);

    // Carry chain into add-with-carry
    wr_icc(4'b0010);
    run_op(1'b0, 4'd1, 32'd5, 32'd7, 1'b0, 0, 1'b0, 1'b0);
    // Single add wrapping to zero
    run_op(1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b0, 1'b0);
    // Multiplies, second with response hold-off
    run_op(1'b1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0);
    run_op(1'b1, 4'd0, 32'h0001_0000, 32'h0001_0000, 1'b1, 5, 1'b0, 1'b0);
    // Sequencer icc update beats direct write; direct write applies when no update
    run_op(1'b0, 4'd0, 32'd1, 32'd2, 1'b1, 0, 1'b0, 1'b1);
    run_op(1'b0, 4'd4, 32'd3, 32'd5, 1'b0, 0, 1'b0, 1'b1);
    // Opcodes without flags never touch icc
    run_op(1'b0, 4'd12, 32'd0, 32'd0, 1'b1, 1, 1'b0, 1'b0);
    // Kill in IDLE does not block the handshake
    run_op(1'b0, 4'd2, 32'd1, 32'd2, 1'b1, 0, 1'b1, 1'b0);
    // Aborts
    kill_op(1'b1, 10, 1'b0);
    kill_op(1'b0, 0, 1'b1);
    kill_op(1'b1, 31, 1'b0);

    for (int n = 0; n < 30; n++) begin
      bit          m;
      logic [31:0] a, b;
      m = ($urandom_range(0, 3) == 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) wr_icc(4'($urandom));
      run_op(m, 4'($urandom), a, b, 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a multiply
    wr_icc(4'b1011);
    req_valid = 1'b1; req_mul = 1'b1; req_setcc = 1'b1; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_ready_busy_valid", {req_ready, busy, rsp_valid}, 3'b100);
    check("midreset_icc_flags", {icc, rsp_flags}, 8'd0);
    check("midreset_rsp", {rsp_hi, rsp_y}, 64'd0);
    check("midreset_alu", {alu_opcode, alu_a, alu_b, alu_cin}, {4'b1101, 65'd0});
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= rsp_valid; end
    check("midreset_no_rsp", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller in front of the 32-bit combinational integer ALU (4-bit opcode, a/b/cin in; y and {Z,N,C,V} flags out).
- Accepts one operation at a time over a valid/ready request port and drives the ALU operand and opcode ports.
- Executes single-cycle ALU ops directly; executes 32x32 unsigned multiply as 32 sequenced ALU add steps.
- Owns the integer condition-code register (icc), presents the result on a valid/ready response port, and sits between decode/issue and writeback.

Parameters:
- MUL_STEPS, 32, number of shift-add iterations; fixed to the data width and not intended to be overridden.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_opcode  input  4  ALU opcode, ignored when req_mul=1
- req_mul  input  1  1 = unsigned multiply req_a*req_b
- req_setcc  input  1  update icc on completion
- req_a  input  32  operand A / multiplicand
- req_b  input  32  operand B / multiplier
- kill  input  1  synchronous abort of the in-flight operation
- alu_a  output  32  to ALU a
- alu_b  output  32  to ALU b
- alu_cin  output  1  to ALU cin
- alu_opcode  output  4  to ALU opcode
- alu_y  input  32  from ALU y
- alu_flags  input  4  from ALU flags {Z,N,C,V}
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_y  output  32  result (low product word for mul)
- rsp_hi  output  32  high product word; 0 for non-mul ops
- rsp_flags  output  4  {Z,N,C,V} of the result
- icc  output  4  condition-code register {Z,N,C,V}
- icc_wr_en  input  1  direct icc write (PSR write path)
- icc_wr_data  input  4  direct icc write data
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, MUL, DONE.
- Reset, asynchronous: state=IDLE; icc, rsp_y, rsp_hi, rsp_flags, step counter and all operand/accumulator registers = 0; rsp_valid=0; req_ready=1; busy=0.
- req_ready=1 only in IDLE. Handshake fires when req_valid && req_ready.
- IDLE, on handshake: latch opcode, mul, setcc, a, b.
  - mul=0 -> EXEC.
  - mul=1 -> MUL with acc_hi=0, mq=b, count=0.
- EXEC, one cycle:
  - ALU driven with alu_opcode=opcode_q, alu_a=a_q, alu_b=b_q, alu_cin=icc[1] (C).
  - Captures rsp_y=alu_y, rsp_hi=0.
  - Opcodes 0000-1001: rsp_flags=alu_flags. Opcodes 1010-1111: rsp_flags=0 and icc never updated.
  - -> DONE.
- MUL, one ALU add per cycle:
  - alu_opcode=0000, alu_a=acc_hi, alu_b = mq[0] ? mcand_q : 0, alu_cin=0.
  - Carry-out is computed locally as (alu_y < acc_hi) unsigned; alu_flags C is not used.
  - Update: {acc_hi, mq} <= {carry, alu_y, mq[31:1]} (33+31 bits, logical right shift of the 64-bit pair after add). count++.
  - When count==MUL_STEPS-1 on this cycle -> DONE with rsp_hi=next acc_hi, rsp_y=next mq, rsp_flags={lo==0, lo[31], 0, 0}, where lo is the low product word.
- Latency: handshake at cycle T.
  - Single op: rsp_valid at T+2.
  - Mul: rsp_valid at T+33.
- icc update:
  - Occurs on the cycle of transition into DONE, only if setcc_q=1, icc <= rsp_flags (next-value).
  - For EXEC with opcode 1010-1111, icc is unchanged even if setcc_q=1.
  - If icc_wr_en is asserted in the same cycle as a sequencer icc update, the sequencer update wins. Otherwise icc_wr_en writes icc_wr_data in any state.
- DONE: rsp_valid=1 with rsp_* stable until rsp_ready=1, then -> IDLE. No request is accepted in the DONE cycle; back-to-back issue costs one IDLE cycle.
- kill=1 in EXEC or MUL:
  - -> IDLE next cycle; no icc update, rsp_valid stays 0.
  - rsp_* keep their previous values, and an icc_wr_en in that cycle still applies.
- kill in IDLE: no effect; a simultaneous request handshake is accepted.
- kill in DONE: no effect; the response completes normally.
- Non-EXEC/MUL states drive alu_opcode=1101, alu_a=0, alu_b=0, alu_cin=0.
- Reset asserted mid-operation aborts immediately to reset values.

Test Plan:
- Reset: assert reset mid-MUL -> all outputs 0, req_ready=1, busy=0 immediately; no rsp_valid after release.
- Single add: opcode 0000, a=0xFFFFFFFF, b=1, setcc=1, rsp_ready=1 -> rsp_valid at T+2, rsp_y=0, rsp_hi=0, icc equals ALU flags (Z=1); returns to IDLE at T+3.
- Carry chain: icc C=1 preloaded via icc_wr_data=4'b0010; opcode 0001, a=5, b=7 -> alu_cin=1 in EXEC, rsp_y=13.
- Multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, setcc=1 -> rsp_valid at T+33, rsp_hi=0xFFFFFFFE, rsp_y=0x00000001, icc=4'b0000.
- Multiply and backpressure: a=0x10000, b=0x10000 with rsp_ready=0 for 5 cycles -> rsp_hi=1, rsp_y=0, icc Z=1 N=0 C=0 V=0, rsp held stable, req_ready=0 until accept.
- Kill and priority: kill at MUL step 10 -> IDLE next cycle, icc unchanged, no rsp. Separately, icc_wr_en=1 with data 4'b1111 on the EXEC cycle of a setcc op -> icc equals sequencer flags.
